// File: rtl/fp16_pkg.sv
// Shared FP16 (1/5/10) constants, operand struct and accumulator FSM state type.
package fp16_pkg;

    localparam int          FP16_BIAS    = 15;
    localparam int          FP16_EXP_W   = 5;
    localparam int          FP16_FRAC_W  = 10;
    localparam logic [15:0] FP16_MAX_POS = 16'h7BFF;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ADD   = 2'd2,
        ST_NORM  = 2'd3
    } fp_acc_state_e;

endpackage

// File: rtl/fp16_accumulator_if.sv
// Product stream in / dot-product result out, shared by the multiplier side and the accumulator.
interface fp16_acc_if;
    import fp16_pkg::*;

    logic                                    in_valid;
    logic                                    in_ready;
    logic [FP16_EXP_W+FP16_FRAC_W:0]         in_data;
    logic                                    in_last;
    logic                                    out_valid;
    logic [FP16_EXP_W+FP16_FRAC_W:0]         out_data;

    modport master (output in_valid, in_data, in_last,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_last,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/fp16_accumulator_lzc.sv
// Combinational leading-zero counter over a 15-bit significand; reused by later adder stages.
module fp16_lzc (
    input  logic [14:0] i_val,
    output logic [3:0]  o_cnt,
    output logic        o_zero
);
    always_comb begin
        o_cnt  = 4'd15;
        o_zero = ~|i_val;
        // Scanning upward leaves the position of the highest set bit.
        for (int i = 0; i < 15; i++) begin
            if (i_val[i]) o_cnt = 4'(14 - i);
        end
    end
endmodule

// File: rtl/fp16_accumulator.sv
// Sequential FP16 accumulator: IDLE -> ALIGN -> ADD -> NORM per product, truncating arithmetic.
// Optional sticky saturation flag port acc_overflow under `FP_ACC_OVF_FLAG_EN.
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int GUARD_BITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    fp16_acc_if.slave  bus
`ifdef FP_ACC_OVF_FLAG_EN
    ,
    output logic       acc_overflow
`endif
);
    localparam int SIG_W = FP16_FRAC_W + 1 + GUARD_BITS;

    fp_acc_state_e r_state, w_next;
    logic [DATA_WIDTH-1:0] r_data, r_acc, r_out_data;
    logic r_last, r_out_valid;
    logic [SIG_W-1:0] r_big, r_small;
    logic r_sign_big, r_sign_small, r_sum_sign;
    logic [FP16_EXP_W-1:0] r_exp;
    logic [SIG_W:0] r_sum;

    fp16_t w_op, w_acc;
    logic [SIG_W-1:0] w_sig_op, w_sig_acc, w_small_sh;
    logic [FP16_EXP_W-1:0] w_diff;
    logic w_op_big;
    logic [SIG_W:0] w_sum, w_norm;
    logic w_sum_sign;
    logic [3:0] w_lz;
    logic w_zero, w_flush, w_sat;
    logic signed [6:0] w_exp_n;
    logic [FP16_FRAC_W-1:0] w_frac;
    logic [DATA_WIDTH-1:0] w_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.in_valid) w_next = ST_ALIGN;
            ST_ALIGN: w_next = ST_ADD;
            ST_ADD:   w_next = ST_NORM;
            ST_NORM:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (clear) w_next = ST_IDLE;
    end

    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = r_out_valid;
        bus.out_data  = r_out_data;
    end

    assign w_op      = r_data;
    assign w_acc     = r_acc;
    assign w_sig_op  = {|w_op.exp,  w_op.frac,  {GUARD_BITS{1'b0}}};
    assign w_sig_acc = {|w_acc.exp, w_acc.frac, {GUARD_BITS{1'b0}}};
    assign w_op_big  = (w_op.exp >= w_acc.exp);
    assign w_diff    = w_op_big ? (w_op.exp - w_acc.exp) : (w_acc.exp - w_op.exp);
    assign w_small_sh = (w_diff >= 5'(SIG_W)) ? '0
                      : ((w_op_big ? w_sig_acc : w_sig_op) >> w_diff);

    always_comb begin
        w_sum_sign = r_sign_big;
        if (r_sign_big == r_sign_small) begin
            w_sum = {1'b0, r_big} + {1'b0, r_small};
        end else if (r_big >= r_small) begin
            w_sum = {1'b0, r_big} - {1'b0, r_small};
        end else begin
            w_sum      = {1'b0, r_small} - {1'b0, r_big};
            w_sum_sign = r_sign_small;
        end
    end

    fp16_lzc u_lzc (.i_val(r_sum), .o_cnt(w_lz), .o_zero(w_zero));

    // Leading one belongs at bit SIG_W-1; one leading zero is the carry slot.
    always_comb begin
        w_norm  = r_sum;
        w_exp_n = 7'({2'b00, r_exp});
        if (r_sum[SIG_W]) begin
            w_norm  = r_sum >> 1;
            w_exp_n = w_exp_n + 7'sd1;
        end else if (!w_zero) begin
            w_norm  = r_sum << (w_lz - 4'd1);
            w_exp_n = w_exp_n - 7'({3'b000, w_lz}) + 7'sd1;
        end
        w_frac  = FP16_FRAC_W'(w_norm >> GUARD_BITS);
        w_flush = w_zero || (w_exp_n <= 7'sd0);
        w_sat   = !w_flush && (w_exp_n >= 7'sd31);
        if (w_flush)    w_res = '0;
        else if (w_sat) w_res = {r_sum_sign, FP16_MAX_POS[14:0]};
        else            w_res = {r_sum_sign, w_exp_n[4:0], w_frac};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0; r_last <= 1'b0; r_acc <= '0;
            r_out_valid <= 1'b0; r_out_data <= '0;
            r_big <= '0; r_small <= '0; r_sign_big <= 1'b0; r_sign_small <= 1'b0;
            r_exp <= '0; r_sum <= '0; r_sum_sign <= 1'b0;
        end else if (clear) begin
            r_acc <= '0; r_last <= 1'b0; r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.in_valid) begin
                    r_data <= bus.in_data;
                    r_last <= bus.in_last;
                end
                ST_ALIGN: begin
                    r_big        <= w_op_big ? w_sig_op : w_sig_acc;
                    r_small      <= w_small_sh;
                    r_sign_big   <= w_op_big ? w_op.sign : w_acc.sign;
                    r_sign_small <= w_op_big ? w_acc.sign : w_op.sign;
                    r_exp        <= w_op_big ? w_op.exp : w_acc.exp;
                end
                ST_ADD: begin
                    r_sum      <= w_sum;
                    r_sum_sign <= w_sum_sign;
                end
                ST_NORM: begin
                    r_acc <= r_last ? '0 : w_res;
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FP_ACC_OVF_FLAG_EN
    logic r_ovf;
    // Held through the out_valid cycle, dropped on the edge after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             r_ovf <= 1'b0;
        else if (clear || r_out_valid)         r_ovf <= 1'b0;
        else if (r_state == ST_NORM && w_sat)  r_ovf <= 1'b1;
    end
    assign acc_overflow = r_ovf;
`endif

endmodule

// File: tb/tb_fp16_accumulator.sv
// Randomized self-checking bench for fp16_accumulator against a value-level FP16 sum model.
module tb_fp16_accumulator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
`ifdef FP_ACC_OVF_FLAG_EN
    logic acc_overflow;
`endif

    fp16_acc_if bus ();

    fp16_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
`ifdef FP_ACC_OVF_FLAG_EN
        ,
        .acc_overflow (acc_overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] m_acc = 16'h0000;
    bit m_ovf = 1'b0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sum of two FP16 values: smaller operand truncated to the larger one's
    // 14-bit grid, exact add, then truncated back to an 11-bit significand.
    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                               output bit sat);
        int ea, eb, emax, p, e;
        longint ma, mb, s, mag, fr;
        bit sg;
        sat  = 1'b0;
        ea   = int'(a[14:10]);
        eb   = int'(b[14:10]);
        ma   = (ea == 0) ? 0 : (longint'(a[9:0]) + 1024) * 8;
        mb   = (eb == 0) ? 0 : (longint'(b[9:0]) + 1024) * 8;
        emax = (ea > eb) ? ea : eb;
        ma   = ma >> (emax - ea);
        mb   = mb >> (emax - eb);
        s    = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
        if (s == 0) return 16'h0000;
        sg  = (s < 0);
        mag = sg ? -s : s;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e  = emax + p - 13;
        fr = (p >= 10) ? (mag >> (p - 10)) : (mag << (10 - p));
        if (e <= 0) return 16'h0000;
        if (e >= 31) begin
            sat = 1'b1;
            return {sg, 15'h7BFF};
        end
        return {sg, 5'(e), 10'(fr)};
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check_val("ready_timeout", 16'(bus.in_ready), 16'h1);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the result edge.
    task automatic send(input logic [15:0] d, input bit last);
        logic [15:0] exp_res;
        bit sat;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_last  = 1'($urandom);
        exp_res = model_add(d, m_acc, sat);
        if (sat) m_ovf = 1'b1;
        m_acc = last ? 16'h0000 : exp_res;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("in_ready_busy", 16'(bus.in_ready), 16'h0);
            check_val("out_valid_early", 16'(bus.out_valid), 16'h0);
        end
        @(negedge clk);
        check_val("in_ready_back", 16'(bus.in_ready), 16'h1);
        check_val("out_valid", 16'(bus.out_valid), 16'(last));
        if (last) check_val("out_data", bus.out_data, exp_res);
`ifdef FP_ACC_OVF_FLAG_EN
        check_val("acc_overflow", 16'(acc_overflow), 16'(m_ovf));
`endif
        if (last) m_ovf = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_acc = 16'h0000;
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_fp16();
        int kind;
        logic [4:0] e;
        kind = int'($urandom_range(0, 9));
        if (kind == 0) return {1'($urandom), 15'h0000};
        if (kind == 1) return {1'($urandom), 5'd30, 10'($urandom)};
        e = (kind < 7) ? 5'($urandom_range(10, 20)) : 5'($urandom_range(1, 30));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 16'(bus.in_ready), 16'h1);
        check_val("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check_val("rst_out_data", bus.out_data, 16'h0000);
`ifdef FP_ACC_OVF_FLAG_EN
        check_val("rst_acc_overflow", 16'(acc_overflow), 16'h0);
`endif
        reset = 1'b0;
        @(negedge clk);

        send(16'h3C00, 1'b0); send(16'h3C00, 1'b1);
        check_val("one_plus_one", bus.out_data, 16'h4000);
        send(16'h4000, 1'b0); send(16'h3800, 1'b0); send(16'h3400, 1'b1);
        check_val("two_point_75", bus.out_data, 16'h4180);
        send(16'h3C00, 1'b1);
        check_val("acc_zeroed", bus.out_data, 16'h3C00);
        send(16'h3C00, 1'b0); send(16'hBC00, 1'b1);
        check_val("cancel", bus.out_data, 16'h0000);
        send(16'h3C00, 1'b0); send(16'h1000, 1'b1);
        check_val("truncate", bus.out_data, 16'h3C00);
        send(16'h7BFF, 1'b0); send(16'h7BFF, 1'b1);
        check_val("saturate", bus.out_data, 16'h7BFF);
        send(16'hFBFF, 1'b0); send(16'hFBFF, 1'b1);
        check_val("saturate_neg", bus.out_data, 16'hFBFF);

        // clear during ADD discards the pending product
        bus.in_valid = 1'b1; bus.in_data = 16'h4000; bus.in_last = 1'b0;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        pulse_clear();
        check_val("clear_idle", 16'(bus.in_ready), 16'h1);
        check_val("clear_no_out", 16'(bus.out_valid), 16'h0);
        send(16'h3C00, 1'b1);
        check_val("after_clear", bus.out_data, 16'h3C00);

        // clear coincident with a handshake: product dropped
        send(16'h4400, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = 16'h4800; bus.in_last = 1'b1;
        pulse_clear();
        bus.in_valid = 1'b0;
        check_val("clear_hs_ready", 16'(bus.in_ready), 16'h1);
        send(16'h3800, 1'b1);
        check_val("clear_hs_sum", bus.out_data, 16'h3800);

        // async reset while in ALIGN
        bus.in_valid = 1'b1; bus.in_data = 16'h4000; bus.in_last = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_val("arst_in_ready", 16'(bus.in_ready), 16'h1);
        check_val("arst_out_valid", 16'(bus.out_valid), 16'h0);
        check_val("arst_out_data", bus.out_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        m_acc = 16'h0000;
        m_ovf = 1'b0;
        @(negedge clk);
        send(16'h3C00, 1'b1);
        check_val("after_reset", bus.out_data, 16'h3C00);

        for (int s = 0; s < 60; s++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 14) == 0) pulse_clear();
                send(rand_fp16(), k == len - 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
